// File: rtl/collect_data_if.sv
// Handshake bundle between a word-stream producer and the collect_data vector packer.
// The flush signal exists only when COLLECT_FLUSH_EN is defined.
interface collect_data_if #(
   parameter int unsigned NUM_WORDS = 10,
   parameter int unsigned WORD_W    = 16
);
   logic [WORD_W-1:0]           data_in;
   logic                        in_valid;
   logic                        in_ready;
   logic [NUM_WORDS*WORD_W-1:0] vec_out;
   logic                        vec_valid;
   logic                        vec_ready;
   logic [3:0]                  word_count;
`ifdef COLLECT_FLUSH_EN
   logic                        flush;

   modport slave (
      input  data_in, in_valid, vec_ready, flush,
      output in_ready, vec_out, vec_valid, word_count
   );
   modport master (
      output data_in, in_valid, vec_ready, flush,
      input  in_ready, vec_out, vec_valid, word_count
   );
`else
   modport slave (
      input  data_in, in_valid, vec_ready,
      output in_ready, vec_out, vec_valid, word_count
   );
   modport master (
      output data_in, in_valid, vec_ready,
      input  in_ready, vec_out, vec_valid, word_count
   );
`endif
endinterface

// File: rtl/collect_data.sv
// Packs NUM_WORDS incoming words into one vector (word k at bits [16k+15:16k]) and holds it
// until consumed. Defining COLLECT_FLUSH_EN adds a flush input that emits a zero-filled partial.
module collect_data #(
   parameter int unsigned NUM_WORDS = 10,
   parameter int unsigned WORD_W    = 16
) (
   input logic            clk,
   input logic            rst,
   collect_data_if.slave  bus
);

   typedef enum logic {StFill, StHold} state_e;

   state_e                      state_q, state_d;
   logic [3:0]                  count_q, count_d;
   logic [NUM_WORDS*WORD_W-1:0] vec_q, vec_d;
   logic                        accept;

   assign accept = (state_q == StFill) && bus.in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFill;
         count_q <= '0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         vec_q   <= vec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      vec_d   = vec_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               vec_d[32'(count_q)*WORD_W +: WORD_W] = bus.data_in;
               count_d = count_q + 4'd1;
               if (count_q == 4'(NUM_WORDS - 1)) begin
                  state_d = StHold;
               end
            end
`ifdef COLLECT_FLUSH_EN
            // An accepted word on the flush edge is kept; zero-fill covers only the lanes after it.
            if (bus.flush && (count_q != 4'd0)) begin
               for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                  if (i >= 32'(count_d)) begin
                     vec_d[i*WORD_W +: WORD_W] = '0;
                  end
               end
               state_d = StHold;
            end
`endif
         end
         StHold: begin
            if (bus.vec_ready) begin
               state_d = StFill;
               count_d = '0;
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   // Outputs are decoded from registered state only.
   assign bus.in_ready   = (state_q == StFill);
   assign bus.vec_valid  = (state_q == StHold);
   assign bus.word_count = count_q;
   assign bus.vec_out    = vec_q;

endmodule

// File: tb/tb_collect_data.sv
// Directed self-checking bench for collect_data; inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_collect_data;

   localparam int unsigned NW = 10;
   localparam int unsigned WW = 16;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   collect_data_if #(.NUM_WORDS(NW), .WORD_W(WW)) bus ();

   collect_data #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.data_in  = '0;
      bus.vec_ready = 1'b0;
`ifdef COLLECT_FLUSH_EN
      bus.flush    = 1'b0;
`endif
      tick();
      tick();
      checks++;
      if (bus.vec_valid !== 1'b0) begin
         errors++; $display("FAIL reset_vec_valid: got %b want 0", bus.vec_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      checks++;
      if (bus.word_count !== 4'd0) begin
         errors++; $display("FAIL reset_word_count: got %0d want 0", bus.word_count);
      end
      checks++;
      if (bus.vec_out !== '0) begin
         errors++; $display("FAIL reset_vec_out: got %h want 0", bus.vec_out);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      logic [NW*WW-1:0] expv;
      logic [NW*WW-1:0] held;
      for (int i = 0; i < int'(NW); i++) begin
         bus.data_in  = 16'(i + 1);
         bus.in_valid = 1'b1;
         expv[i*WW +: WW] = 16'(i + 1);
         tick();
      end
      checks++;
      if (bus.vec_valid !== 1'b1) begin
         errors++; $display("FAIL fill_vec_valid: got %b want 1", bus.vec_valid);
      end
      checks++;
      if (bus.word_count !== 4'd10) begin
         errors++; $display("FAIL fill_word_count: got %0d want 10", bus.word_count);
      end
      checks++;
      if (bus.vec_out !== expv) begin
         errors++; $display("FAIL fill_vec_out: got %h want %h", bus.vec_out, expv);
      end
      held = expv;
      bus.data_in = 16'hDEAD;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b0 || bus.vec_out !== held) begin
            errors++;
            $display("FAIL hold_frozen[%0d]: in_ready %b vec_out %h want 0 / %h",
                     c, bus.in_ready, bus.vec_out, held);
         end
      end
   endtask

   task automatic test_consume();
      logic [NW*WW-1:0] expv;
      bus.in_valid  = 1'b0;
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
      checks++;
      if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.word_count !== 4'd0) begin
         errors++;
         $display("FAIL consume: vec_valid %b in_ready %b count %0d want 0 1 0",
                  bus.vec_valid, bus.in_ready, bus.word_count);
      end
      for (int i = 0; i < int'(NW); i++) begin
         bus.data_in  = 16'hF000 + 16'(i);
         bus.in_valid = 1'b1;
         expv[i*WW +: WW] = 16'hF000 + 16'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.vec_out[15:0] !== 16'hF000) begin
         errors++; $display("FAIL second_lane0: got %h want F000", bus.vec_out[15:0]);
      end
      checks++;
      if (bus.vec_out[159:144] !== 16'hF009) begin
         errors++; $display("FAIL second_lane9: got %h want F009", bus.vec_out[159:144]);
      end
      checks++;
      if (bus.vec_out !== expv || bus.vec_valid !== 1'b1) begin
         errors++;
         $display("FAIL second_vec: got %h valid %b want %h 1", bus.vec_out, bus.vec_valid, expv);
      end
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
   endtask

   task automatic test_reset_midfill();
      logic [NW*WW-1:0] expv;
      for (int i = 0; i < 4; i++) begin
         bus.data_in  = 16'h5500 + 16'(i);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.word_count !== 4'd4) begin
         errors++; $display("FAIL midfill_count: got %0d want 4", bus.word_count);
      end
      // Asynchronous: visible before the next clock edge.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.vec_out !== '0 || bus.word_count !== 4'd0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: vec_out %h count %0d in_ready %b want 0 0 1",
                  bus.vec_out, bus.word_count, bus.in_ready);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < int'(NW); i++) begin
         bus.data_in  = 16'h0100 + 16'(i);
         bus.in_valid = 1'b1;
         expv[i*WW +: WW] = 16'h0100 + 16'(i);
         tick();
         checks++;
         if (bus.word_count !== 4'(i + 1)) begin
            errors++; $display("FAIL post_reset_count[%0d]: got %0d want %0d",
                               i, bus.word_count, i + 1);
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.vec_out[15:0] !== 16'h0100) begin
         errors++; $display("FAIL post_reset_lane0: got %h want 0100", bus.vec_out[15:0]);
      end
      checks++;
      if (bus.vec_out !== expv || bus.vec_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_vec: got %h valid %b want %h 1",
                  bus.vec_out, bus.vec_valid, expv);
      end
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
   endtask

   task automatic test_gaps();
      logic [31:0]      pat = 32'b1011_0010_1110_0101_1001_1100_0110_1011;
      logic [NW*WW-1:0] expv = '0;
      logic             mhold = 1'b0;
      logic             prev = 1'b0;
      int               mcount = 0;
      int               w = 0;
      int               vecs = 0;
      int               rises = 0;
      int               hold_cnt = 0;
      int               cyc = 0;
      while (vecs < 3 && cyc < 300) begin
         if (!mhold) begin
            bus.in_valid  = pat[cyc % 32];
            bus.data_in   = 16'h3000 + 16'(w);
            bus.vec_ready = 1'b0;
         end else begin
            bus.in_valid  = 1'b1;
            bus.vec_ready = (hold_cnt == 2);
         end
         tick();
         cyc++;
         if (!mhold) begin
            if (bus.in_valid) begin
               expv[mcount*WW +: WW] = bus.data_in;
               mcount++;
               w++;
               if (mcount == int'(NW)) begin
                  mhold    = 1'b1;
                  hold_cnt = 0;
                  checks++;
                  if (bus.vec_out !== expv) begin
                     errors++;
                     $display("FAIL gaps_vec[%0d]: got %h want %h", vecs, bus.vec_out, expv);
                  end
               end
            end
         end else if (bus.vec_ready) begin
            mhold  = 1'b0;
            mcount = 0;
            vecs++;
         end else begin
            hold_cnt++;
         end
         checks++;
         if (bus.vec_valid !== mhold || bus.word_count !== 4'(mcount)) begin
            errors++;
            $display("FAIL gaps_state[cyc %0d]: valid %b count %0d want %b %0d",
                     cyc, bus.vec_valid, bus.word_count, mhold, mcount);
         end
         if (bus.vec_valid && !prev) rises++;
         prev = bus.vec_valid;
      end
      bus.in_valid  = 1'b0;
      bus.vec_ready = 1'b0;
      checks++;
      if (vecs != 3 || rises != 3) begin
         errors++; $display("FAIL gaps_pulses: vecs %0d pulses %0d want 3 3", vecs, rises);
      end
   endtask

`ifdef COLLECT_FLUSH_EN
   task automatic test_flush();
      logic [NW*WW-1:0] expv = '0;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++;
      if (bus.vec_valid !== 1'b0 || bus.word_count !== 4'd0) begin
         errors++; $display("FAIL flush_empty: valid %b count %0d want 0 0",
                            bus.vec_valid, bus.word_count);
      end
      expv[47:0] = 48'hCCCC_BBBB_AAAA;
      bus.in_valid = 1'b1;
      bus.data_in = 16'hAAAA; tick();
      bus.data_in = 16'hBBBB; tick();
      bus.data_in = 16'hCCCC; tick();
      bus.in_valid = 1'b0;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++;
      if (bus.vec_valid !== 1'b1 || bus.word_count !== 4'd3 || bus.vec_out !== expv) begin
         errors++;
         $display("FAIL flush_partial: valid %b count %0d vec %h want 1 3 %h",
                  bus.vec_valid, bus.word_count, bus.vec_out, expv);
      end
      bus.vec_ready = 1'b1;
      tick();
      bus.vec_ready = 1'b0;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fill();
      test_consume();
      test_reset_midfill();
      test_gaps();
`ifdef COLLECT_FLUSH_EN
      test_flush();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
